// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage sequencer for the pipelined CPU. When the EX/MEM register holds a
// load or store, it issues one request to a variable-latency data memory and
// waits for MemAck. While the access is in flight it stalls the front of the
// pipeline and bubbles the MEM/WB write-register input. Load data (or ERRDATA
// on a timeout) is registered on ReadData and presented in the DONE cycle,
// which is the one cycle where the pipeline advances past the access.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   MemRead    in   EX/MEM load flag
//   MemWrite   in   EX/MEM store flag (a store wins if both flags are set)
//   Address    in   [31:0] EX/MEM ALU result (byte address)
//   WriteData  in   [31:0] EX/MEM store data
//   MemReq     out  registered request to data memory
//   MemWe      out  registered write enable (1 = store, 0 = load)
//   MemAddr    out  [31:0] registered memory address
//   MemWData   out  [31:0] registered memory store data
//   MemAck     in   memory completion, only looked at in WAIT
//   MemRData   in   [31:0] memory read data, valid with MemAck
//   ReadData   out  [31:0] registered load result for MEM/WB
//   Stall      out  combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   BubbleWB   out  combinational, identical to Stall
//   MemErr     out  sticky timeout flag, cleared only by rst
//   dbg_state  out  [1:0] FSM state: 0 = IDLE, 1 = WAIT, 2 = DONE
//
// Handshake: MemReq rises the cycle after an access is detected and stays
// high, with MemWe/MemAddr/MemWData stable, until the first rising edge at
// which MemAck is sampled high (or the timeout fires); it then drops in the
// same edge. MemAck outside of WAIT carries no meaning and is ignored.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BubbleWB,
    output logic        MemErr,
    output logic [1:0]  dbg_state
);

    // The counter only has to reach TIMEOUT-1: the timeout branch leaves
    // WAIT before it could ever wrap.
    localparam int unsigned   CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic           req_n;
    logic           we_n;
    logic [31:0]    addr_n;
    logic [31:0]    wdata_n;
    logic [31:0]    rdata_n;
    logic           err_n;
    logic           stall_c;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            ReadData <= '0;
            MemErr   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            MemReq   <= req_n;
            MemWe    <= we_n;
            MemAddr  <= addr_n;
            MemWData <= wdata_n;
            ReadData <= rdata_n;
            MemErr   <= err_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = MemReq;
        we_n    = MemWe;
        addr_n  = MemAddr;
        wdata_n = MemWData;
        rdata_n = ReadData;
        err_n   = MemErr;
        stall_c = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    // Stall in the detect cycle already, so EX/MEM keeps the
                    // access until it has been carried through DONE.
                    stall_c = 1'b1;
                    addr_n  = Address;
                    wdata_n = WriteData;
                    we_n    = MemWrite;
                    req_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end
            end

            S_WAIT: begin
                stall_c = 1'b1;
                // Ack is checked first so an ack in the last allowed cycle
                // completes the access instead of timing it out.
                if (MemAck) begin
                    if (!MemWe) begin
                        rdata_n = MemRData;
                    end
                    req_n   = 1'b0;
                    state_n = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    err_n   = 1'b1;
                    req_n   = 1'b0;
                    if (!MemWe) begin
                        rdata_n = ERRDATA;
                    end
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_DONE: begin
                // EX/MEM still shows the finished access here; it is the
                // cycle the pipeline advances, so the flags are not re-used.
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign Stall     = stall_c;
    assign BubbleWB  = stall_c;
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Internal consistency properties
    // -------------------------------------------------------------------------
    req_matches_wait: assert property (
        @(posedge clk) disable iff (rst) MemReq == (state == S_WAIT)
    );

    cnt_in_range: assert property (
        @(posedge clk) disable iff (rst) (state == S_WAIT) |-> (cnt <= CNT_LAST)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Drives the MEM-stage sequencer as the pipeline would: an access is held in
// EX/MEM from its detect cycle through its DONE cycle, then the next
// instruction appears. Expected responses come from a small model of the
// access rules (latency = ack delay + 1 or TIMEOUT + 1, load data / ERRDATA /
// unchanged for stores, sticky error) and are queued per access. A monitor
// watches the DUT outputs every cycle and checks the request phase, the
// stall/bubble length and the DONE-cycle results against the queue head.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int          TO   = 6;
    localparam logic [31:0] ERRD = 32'hFFFF_FFFF;
    localparam int          W    = 106;

    // -------------------------------------------------------------------------
    // Clock and reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BubbleWB;
    logic        MemErr;
    logic [1:0]  dbg_state;

    mem_access_ctrl #(
        .TIMEOUT (TO),
        .ERRDATA (ERRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemAck    (MemAck),
        .MemRData  (MemRData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BubbleWB  (BubbleWB),
        .MemErr    (MemErr),
        .dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state and reference model
    // -------------------------------------------------------------------------
    // Entry: {we, addr, wdata, read_data_after, err_after, stall_len}
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_rd  = '0;
    logic         m_err = 1'b0;
    int           tests = 0;
    int           fails = 0;

    function automatic logic [W-1:0] pack(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [31:0] rd,
                                          input logic err, input logic [7:0] len);
        return {we, addr, wdata, rd, err, len};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks (all called at 1 time unit after a rising edge)
    // -------------------------------------------------------------------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            Address   = $urandom;
            WriteData = $urandom;
            MemAck    = 1'($urandom_range(0, 1));
            MemRData  = $urandom;
            @(posedge clk); #1;
        end
        MemAck = 1'b0;
    endtask

    // k = cycle after detect in which MemAck is driven (0 = never).
    // k = TO+1 lands the ack in the DONE cycle, where it must be ignored.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int k, input logic [31:0] rdata);
        logic is_wr;
        logic acked;
        int   len;
        is_wr = wr;
        acked = (k >= 1) && (k <= TO);
        len   = acked ? k + 1 : TO + 1;
        if (!acked) m_err = 1'b1;
        if (!is_wr) m_rd = acked ? rdata : ERRD;
        exp_q.push_back(pack(is_wr, addr, wdata, m_rd, m_err, 8'(len)));

        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wdata;
        MemAck    = 1'($urandom_range(0, 1));
        MemRData  = $urandom;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            // Scramble the EX/MEM operands to prove the request is latched.
            Address   = $urandom;
            WriteData = $urandom;
            MemAck    = (c == k);
            MemRData  = (c == k) ? rdata : $urandom;
        end
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemAck   = 1'b0;
    endtask

    task automatic reset_mid_wait();
        logic [31:0] a;
        logic [31:0] d;
        a = $urandom;
        d = $urandom;
        exp_q.push_back(pack(1'b0, a, d, m_rd, m_err, 8'(TO + 1)));
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        Address   = a;
        WriteData = d;
        MemAck    = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_mid_req_before", MemReq, 1);
        rst     = 1'b1;
        MemRead = 1'b0;
        #1;
        check("rst_mid_req_async", MemReq, 0);
        check("rst_mid_state_idle", dbg_state, 0);
        exp_q.delete();
        m_rd  = '0;
        m_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_readdata", ReadData, 0);
        check("rst_mid_memerr", MemErr, 0);
    endtask

    // -------------------------------------------------------------------------
    // Monitor: compares DUT outputs with the queue head every cycle
    // -------------------------------------------------------------------------
    int           run_len = 0;
    int           bub_len = 0;
    logic [W-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            bub_len = 0;
        end else if (exp_q.size() == 0) begin
            check("idle_stall", Stall, 0);
            check("idle_bubble", BubbleWB, 0);
            check("idle_memreq", MemReq, 0);
            check("idle_readdata", ReadData, m_rd);
            check("idle_memerr", MemErr, m_err);
        end else begin
            e = exp_q[0];
            if (BubbleWB) bub_len++;
            if (Stall) begin
                run_len++;
                if (run_len == 1) begin
                    check("req_detect_cycle", MemReq, 0);
                end else begin
                    check("req_wait", MemReq, 1);
                    check("req_we", MemWe, e[105]);
                    check("req_addr", MemAddr, e[104:73]);
                    check("req_wdata", MemWData, e[72:41]);
                end
                if (run_len > 64) begin
                    check("stall_runaway", 32'(run_len), 32'(e[7:0]));
                    void'(exp_q.pop_front());
                    run_len = 0;
                    bub_len = 0;
                end
            end else begin
                check("stall_len", 32'(run_len), 32'(e[7:0]));
                check("bubble_len", 32'(bub_len), 32'(e[7:0]));
                check("done_memreq", MemReq, 0);
                check("done_readdata", ReadData, e[40:9]);
                check("done_memerr", MemErr, e[8]);
                void'(exp_q.pop_front());
                run_len = 0;
                bub_len = 0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        @(posedge clk); #1;
        check("reset_memreq", MemReq, 0);
        check("reset_memwe", MemWe, 0);
        check("reset_memaddr", MemAddr, 0);
        check("reset_memwdata", MemWData, 0);
        check("reset_readdata", ReadData, 0);
        check("reset_stall", Stall, 0);
        check("reset_bubble", BubbleWB, 0);
        check("reset_memerr", MemErr, 0);
        check("reset_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        idle(8);
        access(1'b1, 1'b0, 32'h0000_0040, $urandom, 1, 32'h1234_5678);
        idle(2);
        access(1'b0, 1'b1, $urandom, 32'hCAFE_F00D, 5, $urandom);
        access(1'b1, 1'b0, $urandom, $urandom, TO, 32'hA5A5_0001);
        access(1'b1, 1'b1, $urandom, $urandom, 1, $urandom);
        idle(1);
        access(1'b1, 1'b0, $urandom, $urandom, 0, $urandom);
        idle(10);
        access(1'b0, 1'b1, $urandom, $urandom, TO + 1, $urandom);
        idle(10);

        reset_mid_wait();
        idle(2);
        access(1'b1, 1'b0, $urandom, $urandom, 3, 32'h0BAD_BEEF);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            idle($urandom_range(0, 3));
            access(sel != 1, sel != 0, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom);
        end
        idle(5);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the pipelined CPU. It drives a variable-latency data memory through a request/acknowledge handshake. While an access is in flight it freezes the front of the pipeline and inserts a bubble into the MEM/WB register. It delivers load data to the MEM/WB data input, and flags accesses that never complete with a sticky error.

## Interface
Parameters:
- TIMEOUT, 16: maximum WAIT cycles before an access is aborted; legal range ≥ 2.
- ERRDATA, 32'hFFFFFFFF: value returned on ReadData when a load times out.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- MemRead  input  1  EX/MEM load flag.
- MemWrite  input  1  EX/MEM store flag.
- Address  input  32  EX/MEM ALU result (byte address).
- WriteData  input  32  EX/MEM store data.
- MemReq  output  1  registered request to data memory.
- MemWe  output  1  registered write enable; 1 = store, 0 = load.
- MemAddr  output  32  registered memory address.
- MemWData  output  32  registered memory store data.
- MemAck  input  1  memory completion; sampled only in WAIT.
- MemRData  input  32  memory read data; valid when MemAck = 1.
- ReadData  output  32  registered load result, fed to the MEM/WB data input.
- Stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- BubbleWB  output  1  combinational; forces the MEM/WB write-register input to 0.
- MemErr  output  1  sticky timeout flag; cleared only by rst.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- IDLE:
  - If MemRead|MemWrite, assert Stall.
  - Latch Address→MemAddr and WriteData→MemWData.
  - Set MemWe = MemWrite; a write wins if both flags are set.
  - Set MemReq = 1, clear the counter, and go to WAIT.
  - Otherwise remain in IDLE with Stall = 0.
- WAIT:
  - Stall = 1. MemReq and the latched address/data are held stable.
  - If MemAck: for a load, ReadData ← MemRData; for a store, ReadData is unchanged. Then MemReq ← 0, go to DONE.
  - Else if counter == TIMEOUT−1: MemErr ← 1, MemReq ← 0, ReadData ← ERRDATA (loads only), go to DONE.
  - Else counter ← counter + 1.
  - An ack in the final allowed cycle wins over timeout.
- DONE:
  - Stall = 0, so EX/MEM advances and MEM/WB captures ReadData plus the original control.
  - Go to IDLE unconditionally.
  - The access flags still present in EX/MEM during DONE do not start a new access.
- BubbleWB == Stall at all times. This prevents the stalled instruction from being written back more than once.
- MemAck in IDLE or DONE is ignored.
- The counter is $clog2(TIMEOUT) bits wide and never wraps, because timeout forces the exit.

## Timing
- Reset values: state IDLE, MemReq 0, MemWe 0, MemAddr 0, MemWData 0, ReadData 0, MemErr 0, counter 0. Stall and BubbleWB are therefore 0.
- Reset asserted mid-WAIT aborts the access, and MemReq drops immediately (asynchronously). No error is flagged.
- Access detected in cycle N:
  - MemReq is high from N+1.
  - Ack in cycle N+k (k ≥ 1) puts the FSM in DONE at N+k+1.
  - Stall is high for k+1 cycles (N..N+k).
  - ReadData is valid in DONE.
- Minimum-latency access: 2 stall cycles, then DONE. Back-to-back accesses are therefore spaced at least 3 cycles apart.
- Timeout: Stall is high for TIMEOUT+1 cycles. MemErr rises in the DONE cycle and stays high.
- Non-memory instructions: zero added latency, Stall = 0.

## Test plan
- Reset then idle: rst pulse with no access → all outputs 0; ALU instructions flow with Stall = 0 every cycle.
- Load, ack on first WAIT cycle:
  - Stimulus: MemRead = 1, Address = 0x40, MemRData = 0x12345678 with MemAck in N+1.
  - Expect Stall high in N and N+1, MemReq high only in N+1, MemAddr = 0x40, ReadData = 0x12345678 in N+2, Stall = 0 in N+2.
- Store with 5-cycle ack:
  - Stimulus: MemWrite = 1, WriteData = 0xCAFEF00D, MemAck in N+5.
  - Expect MemWe = 1 and MemWData = 0xCAFEF00D stable for N+1..N+5, Stall high for 6 cycles, ReadData unchanged.
- Timeout with TIMEOUT = 4:
  - Stimulus: load with MemAck never asserted.
  - Expect Stall high for 5 cycles, ReadData = 0xFFFFFFFF and MemErr = 1 in DONE; MemErr still 1 after 10 more idle cycles.
- Ack in the final timeout cycle (TIMEOUT = 4): ack in the 4th WAIT cycle → ReadData = MemRData, MemErr stays 0.
- Reset mid-WAIT: rst asserted in the 2nd WAIT cycle → MemReq is 0 immediately and state is IDLE. The next load after reset completes normally.
